// File: rtl/alphasoc_busmux.sv
// One-master to NSLV-slave decoder/multiplexer for the alphacore memory bus.
// Table-driven decode, registered slave requests, unmapped and timeout errors.
module alphasoc_busmux #(
  parameter int NSLV = 4,
  parameter logic [32*NSLV-1:0] SLV_BASE =
    {32'h0400_0000, 32'h0300_0000, 32'h0200_0000, 32'h0000_0000},
  parameter logic [32*NSLV-1:0] SLV_MASK =
    {32'hFF00_0000, 32'hFF00_0000, 32'hFFFF_FFF0, 32'hFF00_0000},
  parameter int TIMEOUT = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m_valid,
  input  logic [31:0]       m_addr,
  input  logic [31:0]       m_wdata,
  input  logic [3:0]        m_wstrb,
  output logic              m_ready,
  output logic [31:0]       m_rdata,
  output logic [NSLV-1:0]   s_valid,
  output logic [31:0]       s_addr,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wstrb,
  input  logic [NSLV-1:0]   s_ready,
  input  logic [32*NSLV-1:0] s_rdata,
  input  logic              err_clr,
  output logic              err_valid,
  output logic [1:0]        err_cause,
  output logic [31:0]       err_addr,
  output logic [7:0]        err_count
);

  typedef enum logic [1:0] {
    IDLE, ACTIVE, RESP, ERR
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  sel_q, sel_d, hit_sel;
  logic        hit;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] cnt_q, cnt_d;
  logic        ev_q, ev_d;
  logic [1:0]  ec_q, ec_d;
  logic [31:0] ea_q, ea_d;
  logic [7:0]  en_q, en_d;
  logic [NSLV-1:0] onehot;
  logic [31:0] rsel;
  logic        rdy, tmo;
  logic        err_en;
  logic [1:0]  err_new;
  logic [31:0] err_a;

  // Descending scan so the lowest matching slot is the last writer.
  always_comb begin
    hit     = 1'b0;
    hit_sel = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((m_addr & SLV_MASK[32*i +: 32]) ==
          SLV_BASE[32*i +: 32]) begin
        hit     = 1'b1;
        hit_sel = 4'(i);
      end
    end
  end

  always_comb begin
    onehot = '0;
    rsel   = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q == 4'(i)) begin
        onehot[i] = 1'b1;
        rsel      = s_rdata[32*i +: 32];
      end
    end
  end

  assign rdy = |(s_ready & onehot);
  assign tmo = (TIMEOUT != 0) &&
               (cnt_q == 32'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_en  = 1'b0;
    err_new = 2'b00;
    err_a   = addr_q;
    unique case (state_q)
      IDLE: begin
        if (m_valid) begin
          addr_d  = m_addr;
          wdata_d = m_wdata;
          wstrb_d = m_wstrb;
          cnt_d   = '0;
          if (hit) begin
            sel_d   = hit_sel;
            state_d = ACTIVE;
          end else begin
            state_d = ERR;
            err_en  = 1'b1;
            err_new = 2'b01;
            err_a   = m_addr;
          end
        end
      end
      ACTIVE: begin
        cnt_d = cnt_q + 32'd1;
        if (rdy) begin
          rdata_d = rsel;
          state_d = RESP;
        end else if (tmo) begin
          state_d = ERR;
          err_en  = 1'b1;
          err_new = 2'b10;
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A new error outranks a simultaneous clear.
  always_comb begin
    ev_d = ev_q;
    ec_d = ec_q;
    ea_d = ea_q;
    en_d = en_q;
    if (err_en) begin
      ev_d = 1'b1;
      ec_d = err_new;
      ea_d = err_a;
      if (en_q != 8'hFF) en_d = en_q + 8'd1;
    end else if (err_clr) begin
      ev_d = 1'b0;
      ec_d = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      ev_q    <= 1'b0;
      ec_q    <= 2'b00;
      ea_q    <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      ev_q    <= ev_d;
      ec_q    <= ec_d;
      ea_q    <= ea_d;
      en_q    <= en_d;
    end
  end

  assign s_valid = (state_q == ACTIVE) ? onehot : '0;
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;
  assign s_wstrb = wstrb_q;
  assign m_ready = (state_q == RESP) || (state_q == ERR);
  assign m_rdata = (state_q == RESP) ? rdata_q :
                   (state_q == ERR)  ? ERR_RDATA : '0;

  assign err_valid = ev_q;
  assign err_cause = ec_q;
  assign err_addr  = ea_q;
  assign err_count = en_q;

endmodule

// File: tb/tb_alphasoc_busmux.sv
// Directed bench for alphasoc_busmux with a simple delay-programmable
// slave model; unselected slots hold s_ready high to catch stray ORs.
module tb_alphasoc_busmux;

  logic         clk = 1'b0;
  logic         resetn;
  logic         m_valid;
  logic [31:0]  m_addr, m_wdata;
  logic [3:0]   m_wstrb;
  logic         m_ready;
  logic [31:0]  m_rdata;
  logic [3:0]   s_valid;
  logic [31:0]  s_addr, s_wdata;
  logic [3:0]   s_wstrb;
  logic [3:0]   s_ready;
  logic [127:0] s_rdata;
  logic         err_clr;
  logic         err_valid;
  logic [1:0]   err_cause;
  logic [31:0]  err_addr;
  logic [7:0]   err_count;

  alphasoc_busmux #(.NSLV(4), .TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn),
    .m_valid(m_valid), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .err_clr(err_clr), .err_valid(err_valid),
    .err_cause(err_cause), .err_addr(err_addr),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cur_slot = 0;
  int cur_dly  = 0;
  int wait_cnt = 0;

  always @(posedge clk) begin
    if (!resetn) wait_cnt <= 0;
    else if (s_valid[cur_slot]) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  always_comb begin
    s_ready = ~(4'(1 << cur_slot));
    if (s_valid[cur_slot] && cur_dly >= 0 &&
        wait_cnt == cur_dly)
      s_ready[cur_slot] = 1'b1;
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    else
      n_pass++;
  endtask

  int          lat, svc;
  logic [31:0] got;
  logic        stab, zero_ok, extra;

  task automatic txn(input logic [31:0] a,
                     input logic [31:0] w,
                     input logic [3:0]  st);
    logic done;
    @(negedge clk);
    m_valid = 1'b1;
    m_addr  = a;
    m_wdata = w;
    m_wstrb = st;
    lat = -1; svc = 0; got = '0;
    stab = 1'b1; zero_ok = 1'b1; done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(posedge clk); #1;
      if (s_valid != 4'b0) begin
        svc++;
        if (s_addr !== a || s_wdata !== w ||
            s_wstrb !== st) stab = 1'b0;
        if (s_valid !== 4'(1 << cur_slot)) stab = 1'b0;
      end
      if (m_ready) begin
        lat = c;
        got = m_rdata;
        done = 1'b1;
        m_valid = 1'b0;
      end else if (m_rdata !== 32'h0) zero_ok = 1'b0;
    end
    m_valid = 1'b0;
    @(posedge clk); #1;
    extra = m_ready;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          slot;
    int          dly;
    logic [31:0] srd;
    int          e_lat;
    int          e_sv;
    logic [31:0] e_rd;
    logic [1:0]  e_cause;
  } vec_t;

  vec_t tbl[9];
  int   ecount;

  initial begin
    resetn = 1'b0; m_valid = 1'b0; m_addr = '0;
    m_wdata = '0; m_wstrb = '0; err_clr = 1'b0;
    s_rdata = '0;
    ecount = 0;

    tbl[0] = '{32'h0000_0010, 32'h0, 4'h0, 0, 0,
               32'h1234_5678, 2, 1, 32'h1234_5678, 2'b00};
    tbl[1] = '{32'h0200_0004, 32'hAB, 4'hF, 1, 3,
               32'h0000_5555, 5, 4, 32'h0000_5555, 2'b00};
    tbl[2] = '{32'h0800_0000, 32'h0, 4'h0, 0, 0,
               32'h0, 1, 0, 32'hDEAD_BEEF, 2'b01};
    tbl[3] = '{32'h0300_0100, 32'h0, 4'h0, 2, -1,
               32'h1111_2222, 9, 8, 32'hDEAD_BEEF, 2'b10};
    tbl[4] = '{32'h0400_0020, 32'h0, 4'h0, 3, 1,
               32'hCAFE_F00D, 3, 2, 32'hCAFE_F00D, 2'b00};
    tbl[5] = '{32'h0200_0010, 32'h55, 4'h3, 1, 0,
               32'h0, 1, 0, 32'hDEAD_BEEF, 2'b01};
    tbl[6] = '{32'h0300_0008, 32'h0, 4'h0, 2, 7,
               32'h0BAD_C0DE, 9, 8, 32'h0BAD_C0DE, 2'b00};
    tbl[7] = '{32'h00FF_FFFC, 32'h0, 4'h0, 0, 2,
               32'h8765_4321, 4, 3, 32'h8765_4321, 2'b00};
    tbl[8] = '{32'hFF00_0000, 32'h77, 4'hF, 0, 0,
               32'h0, 1, 0, 32'hDEAD_BEEF, 2'b01};

    repeat (3) @(posedge clk);
    #1;
    chk("rst m_ready", 32'(m_ready), 32'h0);
    chk("rst s_valid", 32'(s_valid), 32'h0);
    chk("rst m_rdata", m_rdata, 32'h0);
    chk("rst err_valid", 32'(err_valid), 32'h0);
    chk("rst err_count", 32'(err_count), 32'h0);
    chk("rst s_addr", s_addr, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    for (int k = 0; k < 9; k++) begin
      cur_slot = tbl[k].slot;
      cur_dly  = tbl[k].dly;
      for (int i = 0; i < 4; i++)
        s_rdata[32*i +: 32] = (i == tbl[k].slot) ?
          tbl[k].srd : {8'(i + 1), 24'hEEEEEE};
      txn(tbl[k].addr, tbl[k].wdata, tbl[k].wstrb);
      if (tbl[k].e_cause != 2'b00) ecount++;
      chk($sformatf("v%0d latency", k), 32'(lat),
          32'(tbl[k].e_lat));
      chk($sformatf("v%0d m_rdata", k), got, tbl[k].e_rd);
      chk($sformatf("v%0d s_valid cycles", k), 32'(svc),
          32'(tbl[k].e_sv));
      chk($sformatf("v%0d s_bus stable", k), 32'(stab), 32'h1);
      chk($sformatf("v%0d rdata idle zero", k),
          32'(zero_ok), 32'h1);
      chk($sformatf("v%0d single m_ready", k),
          32'(extra), 32'h0);
      chk($sformatf("v%0d err_count", k), 32'(err_count),
          32'(ecount));
      if (tbl[k].e_cause != 2'b00) begin
        chk($sformatf("v%0d err_valid", k),
            32'(err_valid), 32'h1);
        chk($sformatf("v%0d err_cause", k),
            32'(err_cause), 32'(tbl[k].e_cause));
        chk($sformatf("v%0d err_addr", k),
            err_addr, tbl[k].addr);
      end
    end

    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk); #1;
    chk("clr err_valid", 32'(err_valid), 32'h0);
    chk("clr err_cause", 32'(err_cause), 32'h0);
    chk("clr keeps count", 32'(err_count), 32'(ecount));
    chk("clr keeps addr", err_addr, 32'hFF00_0000);
    @(negedge clk);
    err_clr = 1'b0;

    cur_slot = 2;
    cur_dly  = -1;
    m_valid  = 1'b1;
    m_addr   = 32'h0300_0040;
    repeat (3) @(posedge clk);
    #1;
    chk("mid s_valid", 32'(s_valid), 32'h4);
    @(negedge clk);
    resetn  = 1'b0;
    m_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid rst s_valid", 32'(s_valid), 32'h0);
    chk("mid rst m_ready", 32'(m_ready), 32'h0);
    chk("mid rst err_count", 32'(err_count), 32'h0);
    extra = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (m_ready) extra = 1'b1;
    end
    chk("mid rst no m_ready", 32'(extra), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    ecount = 0;

    cur_slot = 0;
    cur_dly  = 0;
    s_rdata[31:0] = 32'h0A0B_0C0D;
    txn(32'h0000_0100, 32'h0, 4'h0);
    chk("post rst latency", 32'(lat), 32'd2);
    chk("post rst m_rdata", got, 32'h0A0B_0C0D);

    for (int n = 0; n < 300; n++)
      txn(32'h0800_0000 + 32'(n), 32'h0, 4'h0);
    chk("sat err_count", 32'(err_count), 32'd255);
    chk("sat err_valid", 32'(err_valid), 32'h1);
    chk("sat err_addr", err_addr, 32'h0800_012B);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
